// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the reserved-op test.
package bshift_pkg;

   typedef logic [2:0] bshift_op_t;

   localparam bshift_op_t OP_SLL = 3'b000;
   localparam bshift_op_t OP_SRL = 3'b001;
   localparam bshift_op_t OP_SRA = 3'b010;
   localparam bshift_op_t OP_ROL = 3'b011;
   localparam bshift_op_t OP_ROR = 3'b100;

   function automatic logic is_reserved(input bshift_op_t op);
      return (op > OP_ROR);
   endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result stream bundle for the barrel shifter; the shifter is the
// slave, the producer/consumer side is the master.
interface barrel_shifter_pipe_if #(
   parameter int WIDTH = 8
);
   import bshift_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   bshift_op_t       in_op;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero, out_err
   );

endinterface

// File: rtl/barrel_shifter_pipe_stage.sv
// One log-stage of the shifter: conditional fixed shift by SHIFT, carry update,
// and a registered valid/ready pipeline slot.
module bshift_stage
   import bshift_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int SHIFT = 1,
   localparam int SHW   = $clog2(WIDTH),
   localparam int BIT   = $clog2(SHIFT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic [SHW-1:0]   i_amt,
   input  bshift_op_t       i_op,
   input  logic             i_carry,
   input  logic             i_err,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [SHW-1:0]   o_amt,
   output bshift_op_t       o_op,
   output logic             o_carry,
   output logic             o_err
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SHW-1:0]   r_amt;
   bshift_op_t       r_op;
   logic             r_carry;
   logic             r_err;

   logic             w_shift;
   logic [WIDTH-1:0] w_data;
   logic             w_carry;
   logic             w_load;

   // Reserved ops pass through untouched so the carry stays at its initial 0.
   assign w_shift = i_amt[BIT] && !i_err;

   always_comb begin
      w_data  = i_data;
      w_carry = i_carry;
      if (w_shift) begin
         case (i_op)
            OP_SLL: begin
               w_data  = {i_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
               w_carry = i_data[WIDTH-SHIFT];
            end
            OP_SRL: begin
               w_data  = {{SHIFT{1'b0}}, i_data[WIDTH-1:SHIFT]};
               w_carry = i_data[SHIFT-1];
            end
            OP_SRA: begin
               // MSB of an arithmetic shift is invariant, so it is still the original sign.
               w_data  = {{SHIFT{i_data[WIDTH-1]}}, i_data[WIDTH-1:SHIFT]};
               w_carry = i_data[SHIFT-1];
            end
            OP_ROL: begin
               w_data  = {i_data[WIDTH-SHIFT-1:0], i_data[WIDTH-1:WIDTH-SHIFT]};
               w_carry = i_data[WIDTH-SHIFT];
            end
            OP_ROR: begin
               w_data  = {i_data[SHIFT-1:0], i_data[WIDTH-1:SHIFT]};
               w_carry = i_data[SHIFT-1];
            end
            default: begin
               w_data  = i_data;
               w_carry = i_carry;
            end
         endcase
      end
   end

   assign w_load  = !r_valid || i_ready;
   assign o_ready = w_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_amt   <= '0;
         r_op    <= OP_SLL;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data  <= w_data;
            r_amt   <= i_amt;
            r_op    <= i_op;
            r_carry <= w_carry;
            r_err   <= i_err;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_amt   = r_amt;
   assign o_op    = r_op;
   assign o_carry = r_carry;
   assign o_err   = r_err;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: SHW registered log-stages chained with
// valid/ready, flags derived from the final stage register.
module barrel_shifter_pipe
   import bshift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   barrel_shifter_pipe_if.slave  bus
);

   logic             w_valid [SHW+1];
   logic             w_ready [SHW+1];
   logic [WIDTH-1:0] w_data  [SHW+1];
   logic [SHW-1:0]   w_amt   [SHW+1];
   bshift_op_t       w_op    [SHW+1];
   logic             w_carry [SHW+1];
   logic             w_err   [SHW+1];
   logic             w_unused;

   assign w_valid[0]   = bus.in_valid;
   assign w_data[0]    = bus.in_data;
   assign w_amt[0]     = bus.in_amt;
   assign w_op[0]      = bus.in_op;
   assign w_carry[0]   = 1'b0;
   assign w_err[0]     = is_reserved(bus.in_op);
   assign w_ready[SHW] = bus.out_ready;
   assign bus.in_ready = w_ready[0];

   for (genvar g = 0; g < SHW; g++) begin : g_stage
      bshift_stage #(
         .WIDTH (WIDTH),
         .SHIFT (1 << g)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_valid (w_valid[g]),
         .o_ready (w_ready[g]),
         .i_data  (w_data[g]),
         .i_amt   (w_amt[g]),
         .i_op    (w_op[g]),
         .i_carry (w_carry[g]),
         .i_err   (w_err[g]),
         .o_valid (w_valid[g+1]),
         .i_ready (w_ready[g+1]),
         .o_data  (w_data[g+1]),
         .o_amt   (w_amt[g+1]),
         .o_op    (w_op[g+1]),
         .o_carry (w_carry[g+1]),
         .o_err   (w_err[g+1])
      );
   end

   assign bus.out_valid = w_valid[SHW];
   assign bus.out_data  = w_data[SHW];
   assign bus.out_carry = w_carry[SHW];
   assign bus.out_err   = w_err[SHW];
   // Gated by valid so the flag reads 0 out of reset and on an empty slot.
   assign bus.out_zero  = w_valid[SHW] && (w_data[SHW] == '0);

   // Amount and op are no longer needed once the last stage has shifted.
   assign w_unused = ^{w_amt[SHW], w_op[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and scoreboard bench for barrel_shifter_pipe at WIDTH=8 (three stages).
module tb_barrel_shifter_pipe;
   import bshift_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic       z;
      logic       e;
      int         cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   barrel_shifter_pipe_if #(.WIDTH(8)) bus ();

   barrel_shifter_pipe #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   beat_t exp_q[$];
   beat_t got_q[$];

   function automatic beat_t model(input logic [7:0] d, input logic [2:0] a, input logic [2:0] o);
      beat_t r;
      int    ai;
      ai    = int'(a);
      r.d   = d;
      r.c   = 1'b0;
      r.e   = 1'b0;
      r.cyc = 0;
      case (o)
         3'd0: begin r.d = d << ai; if (ai != 0) r.c = d[8-ai]; end
         3'd1: begin r.d = d >> ai; if (ai != 0) r.c = d[ai-1]; end
         3'd2: begin r.d = 8'($signed(d) >>> ai); if (ai != 0) r.c = d[ai-1]; end
         3'd3: begin r.d = (d << ai) | (d >> (8 - ai)); if (ai != 0) r.c = r.d[0]; end
         3'd4: begin r.d = (d >> ai) | (d << (8 - ai)); if (ai != 0) r.c = r.d[7]; end
         default: r.e = 1'b1;
      endcase
      r.z = (r.d == 8'h00);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      beat_t eb;
      beat_t gb;
      if (!rst) begin
         if (bus.in_valid && bus.in_ready) begin
            eb     = model(bus.in_data, bus.in_amt, bus.in_op);
            eb.cyc = cyc;
            exp_q.push_back(eb);
         end
         if (bus.out_valid && bus.out_ready) begin
            gb.d   = bus.out_data;
            gb.c   = bus.out_carry;
            gb.z   = bus.out_zero;
            gb.e   = bus.out_err;
            gb.cyc = cyc;
            got_q.push_back(gb);
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] o);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_op    = o;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
      end
   endtask

   task automatic wait_got(input int n, input int limit);
      int k;
      k = 0;
      while (got_q.size() < n && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic xact(input logic [7:0] d, input logic [2:0] a, input logic [2:0] o,
                       output beat_t b, output logic ok);
      exp_q.delete();
      got_q.delete();
      send(d, a, o);
      wait_got(1, 20);
      ok    = (got_q.size() > 0);
      b.d   = 8'h00;
      b.c   = 1'b0;
      b.z   = 1'b0;
      b.e   = 1'b0;
      b.cyc = 0;
      if (ok) b = got_q.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_carry !== 1'b0 ||
          bus.out_zero !== 1'b0 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: v=%b d=%h c=%b z=%b e=%b rdy=%b, required 0 00 0 0 0 1",
                  bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err, bus.in_ready);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(8'h11, 3'd1, OP_SLL);
      send(8'h22, 3'd2, OP_SRL);
      send(8'h33, 3'd3, OP_ROL);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_3_beats: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midstream: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
      exp_q.delete();
      got_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL stale_beat: %0d beats emerged after reset, required 0", got_q.size());
      end
   endtask

   task automatic test_shift_ops();
      logic [7:0] vd [5] = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5};
      logic [2:0] vo [5] = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
      logic [7:0] ed [5] = '{8'hA8, 8'h16, 8'hF6, 8'hAD, 8'hB6};
      beat_t b;
      logic  ok;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         xact(vd[i], 3'd3, vo[i], b, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL shift_op[%0d]: no result, required d=%h", i, ed[i]);
         end else if (b.d !== ed[i] || b.c !== 1'b1 || b.z !== 1'b0 || b.e !== 1'b0) begin
            errors++;
            $display("FAIL shift_op[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=1 z=0 e=0",
                     i, b.d, b.c, b.z, b.e, ed[i]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [7:0] vd [6] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h80};
      logic [2:0] va [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      logic [2:0] vo [6] = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_SLL};
      logic [7:0] ed [6] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h00};
      logic       ec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       ez [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      beat_t b;
      logic  ok;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         xact(vd[i], va[i], vo[i], b, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL boundary[%0d]: no result, required d=%h", i, ed[i]);
         end else if (b.d !== ed[i] || b.c !== ec[i] || b.z !== ez[i] || b.e !== 1'b0) begin
            errors++;
            $display("FAIL boundary[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=%b z=%b e=0",
                     i, b.d, b.c, b.z, b.e, ed[i], ec[i], ez[i]);
         end
      end
   endtask

   task automatic test_reserved();
      logic [7:0] vd [3] = '{8'h3C, 8'h00, 8'hA5};
      logic [2:0] va [3] = '{3'd5, 3'd2, 3'd7};
      logic [2:0] vo [3] = '{3'b110, 3'b111, 3'b101};
      logic       ez [3] = '{1'b0, 1'b1, 1'b0};
      beat_t b;
      logic  ok;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         xact(vd[i], va[i], vo[i], b, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL reserved[%0d]: no result, required d=%h e=1", i, vd[i]);
         end else if (b.d !== vd[i] || b.c !== 1'b0 || b.z !== ez[i] || b.e !== 1'b1) begin
            errors++;
            $display("FAIL reserved[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=0 z=%b e=1",
                     i, b.d, b.c, b.z, b.e, vd[i], ez[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int gaps;
      bus.out_ready = 1'b1;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 16; i++)
         send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)));
      wait_got(16, 40);
      checks++;
      if (got_q.size() != 16 || exp_q.size() != 16) begin
         errors++;
         $display("FAIL b2b_count: got %0d accepted %0d, required 16 16", got_q.size(), exp_q.size());
      end else begin
         checks++;
         if (got_q[0].cyc - exp_q[0].cyc != 3) begin
            errors++;
            $display("FAIL b2b_latency: %0d cycles, required 3", got_q[0].cyc - exp_q[0].cyc);
         end
         gaps = 0;
         for (int k = 1; k < 16; k++)
            if (got_q[k].cyc - got_q[k-1].cyc != 1) gaps++;
         checks++;
         if (gaps != 0) begin
            errors++;
            $display("FAIL b2b_throughput: %0d gaps in output stream, required 0", gaps);
         end
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_q[k].d !== exp_q[k].d || got_q[k].c !== exp_q[k].c ||
                got_q[k].z !== exp_q[k].z || got_q[k].e !== exp_q[k].e) begin
               errors++;
               $display("FAIL b2b_beat[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=%b z=%b e=%b",
                        k, got_q[k].d, got_q[k].c, got_q[k].z, got_q[k].e,
                        exp_q[k].d, exp_q[k].c, exp_q[k].z, exp_q[k].e);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int         acc;
      int         idx;
      logic       have;
      logic       stable;
      logic       took;
      logic [7:0] snap;
      acc    = 0;
      idx    = 0;
      have   = 1'b0;
      stable = 1'b1;
      snap   = 8'h00;
      exp_q.delete();
      got_q.delete();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h10 + idx);
         bus.in_amt   = 3'(idx);
         bus.in_op    = 3'(idx % 5);
         @(negedge clk);
         if (bus.out_valid) begin
            if (!have) begin
               snap = bus.out_data;
               have = 1'b1;
            end else if (bus.out_data !== snap) begin
               stable = 1'b0;
            end
         end
         took = bus.in_ready;
         if (took) acc++;
         @(posedge clk);
         #1;
         if (took) idx++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (acc != 3 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: accepts=%0d in_ready=%b, required 3 0", acc, bus.in_ready);
      end
      checks++;
      if (!have || !stable) begin
         errors++;
         $display("FAIL bp_hold: out_valid seen=%b data stable=%b, required 1 1", have, stable);
      end
      bus.out_ready = 1'b1;
      for (int j = idx; j < 8; j++)
         send(8'(8'h10 + j), 3'(j), 3'(j % 5));
      wait_got(8, 40);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 8 || exp_q.size() != 8) begin
         errors++;
         $display("FAIL bp_count: delivered %0d accepted %0d, required 8 8", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_q[k].d !== exp_q[k].d || got_q[k].c !== exp_q[k].c ||
                got_q[k].z !== exp_q[k].z || got_q[k].e !== exp_q[k].e) begin
               errors++;
               $display("FAIL bp_beat[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=%b z=%b e=%b",
                        k, got_q[k].d, got_q[k].c, got_q[k].z, got_q[k].e,
                        exp_q[k].d, exp_q[k].c, exp_q[k].z, exp_q[k].e);
            end
         end
      end
   endtask

   task automatic test_scoreboard();
      logic fin;
      fin = 1'b0;
      exp_q.delete();
      got_q.delete();
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
         end
         begin
            while (!fin) begin
               bus.out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
         end
         begin
            wait_got(1000, 30000);
            fin = 1'b1;
         end
      join
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 1000 || exp_q.size() != 1000) begin
         errors++;
         $display("FAIL sb_count: delivered %0d accepted %0d, required 1000 1000", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < 1000; k++) begin
            checks++;
            if (got_q[k].d !== exp_q[k].d || got_q[k].c !== exp_q[k].c ||
                got_q[k].z !== exp_q[k].z || got_q[k].e !== exp_q[k].e) begin
               errors++;
               $display("FAIL sb_beat[%0d]: got d=%h c=%b z=%b e=%b, required d=%h c=%b z=%b e=%b",
                        k, got_q[k].d, got_q[k].c, got_q[k].z, got_q[k].e,
                        exp_q[k].d, exp_q[k].c, exp_q[k].z, exp_q[k].e);
            end
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_amt    = 3'd0;
      bus.in_op     = OP_SLL;
      bus.out_ready = 1'b0;
      test_reset();
      test_shift_ops();
      test_boundary();
      test_reserved();
      test_back_to_back();
      test_backpressure();
      test_scoreboard();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
